// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor computing d = a - b (mod 2^WIDTH).
//   One full-subtract cell consumes one bit per clock, LSB first, with the
//   borrow held in a register between bits. The result register fills from
//   the MSB side, so after WIDTH shifts it holds the difference in its
//   natural bit order.
//
//   Optional feature: define SERIAL_SUB_OVF_EN to enable the signed overflow
//   flag. When it is undefined, ovf is tied to 0.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a subtraction (accepted only in IDLE)
//   a      in   [WIDTH] minuend, captured with start
//   b      in   [WIDTH] subtrahend, captured with start
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle pulse, result valid
//   d      out  [WIDTH] difference, held until the next completion
//   bout   out  final borrow (a < b unsigned)
//   ovf    out  signed overflow flag
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;
    logic             ovf_q;

    // Full-subtract cell on the current LSBs.
    logic diff, br_nxt;
    assign diff   = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    logic last_bit;
    assign last_bit = (state == RUN) && (cnt == LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            // The operand registers are consumed by shifting, so keep the
            // sign bits separately for the overflow flag.
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {diff, res[WIDTH-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + 1'b1;
        end
    end

    // Outputs change only on the edge that enters DONE. On that edge the
    // current diff is the result MSB and br_nxt is the final borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d     <= '0;
            bout  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            d     <= {diff, res[WIDTH-1:1]};
            bout  <= br_nxt;
            ovf_q <= (a_msb != b_msb) && (diff != a_msb);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed-vector bench for serial_subtractor (WIDTH=8). Stimulus pushes
//   the hand-computed expected {d, bout, ovf} into a queue; a monitor pops
//   and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, bout, ovf;
    logic [7:0] d;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int exp_total = 0;
    logic [9:0] exp_q[$];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic ovf_exp(input logic o);
`ifdef SERIAL_SUB_OVF_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [9:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done with d=0x%0h, expected no done", d);
            end else begin
                e = exp_q.pop_front();
                check("result", {d, bout, ovf}, {22'd0, e});
            end
        end
    end

    // Issue one operation and follow it to completion. inject >= 0 pulses a
    // second start (a=FF, b=00) that many cycles into RUN; it must be ignored.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input bit chk_lat, input int inject);
        int n, busy_n;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        exp_q.push_back({ed, eb, ovf_exp(eo)});
        exp_total++;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v;             // operand changes in RUN have no effect
        n = 0; busy_n = 0;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if (n == inject)     begin start = 1'b1; a = 8'hFF; b = 8'h00; end
            if (n == inject + 1) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 40) check("done_timeout", 32'(n), 32'd8);
        if (chk_lat) begin
            check("busy_cycles", 32'(busy_n), 32'd8);
            check("done_cycle", 32'(n + 1), 32'd9);
            @(negedge clk);
            check("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int n, k;
        int tdone[3];
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, d, bout, ovf}, 32'd0);
        rst_n = 1'b1;

        // Basic and boundary vectors (expected values computed by hand).
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1, -1);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, -1);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, -1);
        run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, -1);
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, -1);
        run_op(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0, -1);

        // Restart attempt during RUN is ignored; result unchanged.
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1, 3);
        repeat (12) @(negedge clk);
        check("single_done_after_inject", 32'(done_cnt), 32'(exp_total));

        // Reset abort at RUN cycle 4: nothing pushed, so any done would fail.
        @(negedge clk);
        a = 8'hC3; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt), 32'(exp_total));
        run_op(8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, -1);

        // Back-to-back with start held high: three operations, 10 cycles apart.
        @(negedge clk);
        a = 8'h03; b = 8'h05; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({8'hFE, 1'b1, 1'b0});
            exp_total++;
        end
        n = 0; k = 0;
        while (k < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (done) begin
                tdone[k] = n;
                k++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        if (k == 3) begin
            check("b2b_first", 32'(tdone[0]), 32'd9);
            check("b2b_interval1", 32'(tdone[1] - tdone[0]), 32'd10);
            check("b2b_interval2", 32'(tdone[2] - tdone[1]), 32'd10);
        end

        repeat (15) @(negedge clk);
        check("done_total", 32'(done_cnt), 32'(exp_total));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("hold_d", {24'd0, d}, 32'h0000_00FE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
